handshake_rr_arbiter: RTL and testbench
=======================================

# handshake_rr_arbiter

Round-robin arbiter that shares one registered valid/ready output channel between `NUM` independent valid/ready value sources. Each source is a flip-flop-output producer, such as an incrementing counter. The block picks one pending source per accepted beat, registers its value, and presents it downstream. It sits between a bank of producers and a single consumer, and sustains one beat per clock when the consumer is always ready.

## Interface
- `NUM`, 4: number of requesters; legal range 2–16.
- `WIDTH`, 8: value width in bits.
- `clock`  in  1: sole clock; all logic is on the rising edge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `i_value`  in  `NUM`×`WIDTH`: per-requester value, unpacked array indexed by requester.
- `i_valid`  in  `NUM`: per-requester valid.
- `o_ready`  out  `NUM`: per-requester ready (grant), combinational.
- `o_value`  out  `WIDTH`: registered arbitrated value.
- `o_valid`  out  1: registered output valid.
- `i_ready`  in  1: downstream ready.
- `o_id`  out  `$clog2(NUM)`: registered source index. Present only with `HANDSHAKE_RR_ARBITER_ID_EN`.

## Operation
- `load = ~o_valid | i_ready`. The output register can take a new beat this cycle.
- `ptr` is the priority pointer, range 0..`NUM`-1. Search order is `ptr`, `ptr+1`, … wrapping modulo `NUM`. `g` is the first index with `i_valid[g]=1`.
- `o_ready[k] = reset_n & load & any(i_valid) & (k==g)`. At most one bit is high.
- Rising edge with `reset_n=0`: `o_valid<=0`, `o_value<='0`, `o_id<='0`, `ptr<=0`.
- Rising edge, `load=1` and `any(i_valid)=1`: `o_value<=i_value[g]`, `o_valid<=1`, `o_id<=g`, `ptr<=(g+1)%NUM`.
- Rising edge, `load=1` and no request: `o_valid<=0` (only a change if a beat was drained). `o_value`, `o_id` and `ptr` hold.
- Rising edge, `load=0` (stall: `o_valid=1`, `i_ready=0`): all registers hold. The downstream beat stays stable until accepted.
- A transfer on each side is `valid & ready` at a rising edge, sampled on that edge.
- Requesters must hold `i_value` and `i_valid` until their `o_ready` is seen. The arbiter never drops or duplicates a beat.

## Timing
- Latency: a beat accepted at edge N appears on `o_value`/`o_valid` after edge N and is visible at edge N+1.
- Throughput: one beat per cycle when `i_ready` stays high. This includes a back-to-back drain and reload in the same edge.
- Fairness: with all `NUM` sources continuously valid, grants go 0,1,…,`NUM`-1,0,… Any waiting source is served within `NUM` accepted beats.
- Wrap-around: a grant to `NUM`-1 sets `ptr` to 0.
- Single source: a lone valid source is granted every `load` cycle regardless of `ptr`.
- Reset mid-operation: a beat pending in the output register is discarded. `o_ready` is 0 during the reset cycle, so no source transfer is counted.
- `i_ready` rising while `o_valid=0` has no effect.

## Configuration
- `HANDSHAKE_RR_ARBITER_ID_EN` defined: the `o_id` port and its register exist and track the source of `o_value`.
- Macro undefined: the `o_id` port and its register are absent, and the remaining behaviour is identical.

## Structure
- Package `handshake_pkg` holds:
  - `typedef bit [7:0] value_t`;
  - `localparam` defaults `NUM=4` and `WIDTH=8`;
  - function `id_width(num)` returning `$clog2(num)`, minimum 1.
- Sub-module `rr_priority_pick` (purely combinational): inputs `req[NUM]` and `ptr`; outputs a one-hot `grant`, the encoded `idx`, and `any`. The arbiter instantiates it once, and it is tested standalone.

## Test plan
- **Reset**: hold `reset_n=0` for 10 cycles with all `i_valid=1`.
  - Expect `o_valid=0`, `o_value=0`, `o_ready=0` throughout.
  - First grant after release goes to requester 0.
- **Full load**: 4 counter sources, source k emitting k*64+1, k*64+2, …; `i_ready=1` always.
  - Output sequence is 01,41,81,C1,02,42,…
  - One beat per cycle, no gaps.
- **Backpressure**: same sources, `i_ready` toggled randomly (0 for 1–10 cycles).
  - `o_value`/`o_valid` stay stable while stalled.
  - Per-source order is preserved, with no loss or duplication over 100 beats.
- **Sparse**: only source 2 valid with `ptr=3`.
  - Source 2 granted; next `ptr=3`.
  - Source 3 asserting valid in the next cycle wins over source 2.
- **Wrap and single source**: only source 3 valid for 5 beats.
  - Values accepted every cycle; `ptr` settles at 0 after each grant.
  - With the macro defined, `o_id=3` on each beat.
- **Mid-burst reset**: `reset_n=0` for one cycle while `o_valid=1`, `i_ready=0`.
  - Expect `o_valid=0` next cycle; no source sees `o_ready` that cycle.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared types, default parameters and the index-width helper for the
// handshake round-robin arbiter.
package handshake_pkg;

  typedef bit [7:0] value_t;

  localparam int DEFAULT_NUM   = 4;
  localparam int DEFAULT_WIDTH = 8;

  // An index needs at least one bit even when $clog2 would return 0.
  function automatic int id_width(input int num);
    return (num < 2) ? 1 : $clog2(num);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM. Returns a one-hot grant, its index and an any flag.
module rr_priority_pick
  import handshake_pkg::*;
#(
  parameter int NUM = DEFAULT_NUM,
  parameter int IDW = id_width(DEFAULT_NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [NUM-1:0] grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;
  logic           found;

  // Extra bit on sum keeps ptr+i from overflowing before the wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM))
        sum = sum - (IDW+1)'(NUM);
      cand = sum[IDW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging NUM valid/ready sources onto one registered
// output channel. Define HANDSHAKE_RR_ARBITER_ID_EN to add the o_id port.
module handshake_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int NUM   = DEFAULT_NUM,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          i_value [NUM],
  input  logic [NUM-1:0]            i_valid,
  output logic [NUM-1:0]            o_ready,
  output logic [WIDTH-1:0]          o_value,
  output logic                      o_valid,
  input  logic                      i_ready
`ifdef HANDSHAKE_RR_ARBITER_ID_EN
  ,
  output logic [id_width(NUM)-1:0]  o_id
`endif
);

  localparam int IDW = id_width(NUM);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] ptr_next;
  logic [NUM-1:0] pick_grant;
  logic           pick_any;
  logic           load;
  logic           take;

  rr_priority_pick #(
    .NUM (NUM),
    .IDW (IDW)
  ) u_pick (
    .req   (i_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Draining and reloading the output register happen on the same edge.
  assign load     = ~o_valid | i_ready;
  assign take     = load & pick_any;
  assign o_ready  = pick_grant & {NUM{reset_n & take}};
  assign ptr_next = (pick_idx == IDW'(NUM-1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_value <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (pick_any) begin
        o_valid <= 1'b1;
        o_value <= i_value[pick_idx];
        ptr     <= ptr_next;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef HANDSHAKE_RR_ARBITER_ID_EN
  always_ff @(posedge clock) begin
    if (!reset_n)
      o_id <= '0;
    else if (take)
      o_id <= pick_idx;
  end
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter and its rr_priority_pick; checks
// o_id too when HANDSHAKE_RR_ARBITER_ID_EN is defined.
module tb_handshake_rr_arbiter;
  import handshake_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] i_value [4];
  logic [3:0] i_valid;
  logic [3:0] o_ready;
  logic [7:0] o_value;
  logic       o_valid;
  logic       i_ready;
`ifdef HANDSHAKE_RR_ARBITER_ID_EN
  logic [1:0] o_id;
`endif

  logic [3:0] pk_req;
  logic [1:0] pk_ptr;
  logic [3:0] pk_grant;
  logic [1:0] pk_idx;
  logic       pk_any;

  int total_checks = 0;
  int passed_checks = 0;

  // Each source is a counter that advances when its beat is taken.
  logic [7:0] cnt [4] = '{8'h01, 8'h41, 8'h81, 8'hC1};

  always #5 clock = ~clock;

  handshake_rr_arbiter #(.NUM(4), .WIDTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .i_value (i_value),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_value (o_value),
    .o_valid (o_valid),
    .i_ready (i_ready)
`ifdef HANDSHAKE_RR_ARBITER_ID_EN
    ,
    .o_id    (o_id)
`endif
  );

  rr_priority_pick #(.NUM(4), .IDW(2)) pick (
    .req   (pk_req),
    .ptr   (pk_ptr),
    .grant (pk_grant),
    .idx   (pk_idx),
    .any   (pk_any)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) i_value[k] = cnt[k];
  end

  always @(posedge clock) begin
    for (int k = 0; k < 4; k++)
      if (i_valid[k] && o_ready[k]) cnt[k] <= cnt[k] + 8'd1;
  end

  typedef struct packed {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       any;
  } pick_vec_t;

  pick_vec_t vecs [10];

  // Beat j of the all-valid stream comes from source j%4, its (j/4)th value.
  function automatic value_t model(input int j);
    return value_t'((j % 4) * 64 + j / 4 + 1);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic [3:0] valid,
                                input logic rdy);
    @(posedge clock);
    #1;
    reset_n = rst_n;
    i_valid = valid;
    i_ready = rdy;
  endtask

  initial begin
    int     exp_beat;
    int     cycles;
    int     stall_left;
    logic   prev_stall;
    value_t prev_val;
    value_t v;
    logic [7:0] snap [4];

    reset_n = 1'b0;
    i_valid = 4'b1111;
    i_ready = 1'b1;
    pk_req  = '0;
    pk_ptr  = '0;

    vecs[0] = '{4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0};
    vecs[1] = '{4'b1111, 2'd0, 4'b0001, 2'd0, 1'b1};
    vecs[2] = '{4'b1111, 2'd1, 4'b0010, 2'd1, 1'b1};
    vecs[3] = '{4'b1111, 2'd3, 4'b1000, 2'd3, 1'b1};
    vecs[4] = '{4'b0100, 2'd3, 4'b0100, 2'd2, 1'b1};
    vecs[5] = '{4'b0001, 2'd3, 4'b0001, 2'd0, 1'b1};
    vecs[6] = '{4'b1010, 2'd2, 4'b1000, 2'd3, 1'b1};
    vecs[7] = '{4'b1010, 2'd0, 4'b0010, 2'd1, 1'b1};
    vecs[8] = '{4'b0110, 2'd3, 4'b0010, 2'd1, 1'b1};
    vecs[9] = '{4'b1001, 2'd1, 4'b1000, 2'd3, 1'b1};

    for (int n = 0; n < 10; n++) begin
      pk_req = vecs[n].req;
      pk_ptr = vecs[n].ptr;
      #1;
      check_output($sformatf("pick_grant[%0d]", n), pk_grant, vecs[n].grant);
      check_output($sformatf("pick_any[%0d]", n), pk_any, vecs[n].any);
      if (vecs[n].any) check_output($sformatf("pick_idx[%0d]", n), pk_idx, vecs[n].idx);
    end

    // Reset held with every source requesting.
    repeat (10) begin
      @(negedge clock);
      check_output("rst_o_valid", o_valid, 0);
      check_output("rst_o_value", o_value, 0);
      check_output("rst_o_ready", o_ready, 0);
    end
    apply_stimulus(1'b1, 4'b1111, 1'b1);
    @(negedge clock);
    check_output("first_grant", o_ready, 4'b0001);
    check_output("first_ptr", dut.ptr, 0);

    // Full load: one beat per cycle in 0,1,2,3 order.
    for (int j = 0; j < 16; j++) begin
      @(posedge clock);
      @(negedge clock);
      check_output("full_valid", o_valid, 1);
      check_output($sformatf("full_value[%0d]", j), o_value, model(j));
`ifdef HANDSHAKE_RR_ARBITER_ID_EN
      check_output("full_id", o_id, j % 4);
`endif
    end

    // Backpressure: random stalls, every accepted beat must be the next one.
    exp_beat   = 16;
    cycles     = 0;
    stall_left = 0;
    prev_stall = 1'b0;
    prev_val   = '0;
    while (exp_beat < 116 && cycles < 3000) begin
      @(posedge clock);
      #1;
      if (stall_left > 0) begin
        i_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 2) == 0) begin
        i_ready    = 1'b0;
        stall_left = int'($urandom_range(1, 10)) - 1;
      end else begin
        i_ready = 1'b1;
      end
      @(negedge clock);
      if (prev_stall) begin
        check_output("stall_valid", o_valid, 1);
        check_output("stall_value", o_value, prev_val);
      end
      if (o_valid && i_ready) begin
        check_output($sformatf("bp_value[%0d]", exp_beat), o_value, model(exp_beat));
        exp_beat++;
      end
      prev_stall = o_valid && !i_ready;
      prev_val   = o_value;
      cycles++;
    end
    check_output("bp_beats_done", exp_beat, 116);

    // Mid-burst reset while stalled.
    apply_stimulus(1'b1, 4'b1111, 1'b0);
    @(negedge clock);
    check_output("pre_rst_valid", o_valid, 1);
    apply_stimulus(1'b0, 4'b1111, 1'b0);
    @(negedge clock);
    check_output("mid_rst_ready", o_ready, 0);
    for (int k = 0; k < 4; k++) snap[k] = cnt[k];
    apply_stimulus(1'b1, 4'b0000, 1'b0);
    @(negedge clock);
    check_output("mid_rst_valid", o_valid, 0);
    check_output("mid_rst_value", o_value, 0);
    check_output("mid_rst_ptr", dut.ptr, 0);
    for (int k = 0; k < 4; k++)
      check_output($sformatf("mid_rst_cnt[%0d]", k), cnt[k], snap[k]);

    apply_stimulus(1'b1, 4'b0000, 1'b1);
    @(negedge clock);
    check_output("idle_ready_valid", o_valid, 0);
    check_output("idle_ready_grant", o_ready, 0);

    // Sparse: source 2 alone, then source 3 joins once ptr points at it.
    apply_stimulus(1'b1, 4'b0100, 1'b1);
    @(negedge clock);
    check_output("sparse_grant0", o_ready, 4'b0100);
    v = cnt[2];
    @(posedge clock);
    @(negedge clock);
    check_output("sparse_value0", o_value, v);
    check_output("sparse_ptr0", dut.ptr, 3);
    check_output("sparse_grant1", o_ready, 4'b0100);
    v = cnt[2];
    apply_stimulus(1'b1, 4'b1100, 1'b1);
    @(negedge clock);
    check_output("sparse_value1", o_value, v);
    check_output("sparse_ptr1", dut.ptr, 3);
    check_output("sparse_grant3", o_ready, 4'b1000);
    v = cnt[3];
    @(posedge clock);
    @(negedge clock);
    check_output("sparse_value3", o_value, v);
    check_output("sparse_ptr3", dut.ptr, 0);
    check_output("sparse_grant2", o_ready, 4'b0100);
`ifdef HANDSHAKE_RR_ARBITER_ID_EN
    check_output("sparse_id3", o_id, 3);
`endif
    v = cnt[2];
    apply_stimulus(1'b1, 4'b1000, 1'b1);
    @(negedge clock);
    check_output("sparse_value2", o_value, v);

    // Single source 3: granted every cycle, ptr wraps to 0.
    for (int n = 0; n < 5; n++) begin
      check_output($sformatf("single_grant[%0d]", n), o_ready, 4'b1000);
      v = cnt[3];
      @(posedge clock);
      @(negedge clock);
      check_output($sformatf("single_value[%0d]", n), o_value, v);
      check_output("single_valid", o_valid, 1);
      check_output("single_ptr", dut.ptr, 0);
`ifdef HANDSHAKE_RR_ARBITER_ID_EN
      check_output("single_id", o_id, 3);
`endif
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
